receptor_serial: RTL

Seven-bit serial-in/parallel-out receiver. It is the receiving end of the serial link driven by the team's 7-bit parallel-load shift-register transmitter. It samples one bit per enabled clock, MSB first, and assembles 7-bit words. On each completed frame it presents the word on a registered parallel bus with a one-cycle valid pulse. Mode control uses the same two-line `ch1`/`ch0` scheme as the transmitter, so both ends can be driven from one controller.

---
 rtl/receptor_serial.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/receptor_serial.sv
// 7-bit MSB-first serial-in/parallel-out receiver, mode on {ch1,ch0}: 00 hold, 01 receive, 10 clear, 11 abort.
// Optional even-parity 8th bit: define RECEPTOR_PARIDADE_EN.
module receptor_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       ch0,
  input  logic       ch1,
  output logic [6:0] saidas_receptor,
  output logic       valido,
  output logic       ocupado,
  output logic       erro_paridade
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
`ifdef RECEPTOR_PARIDADE_EN
    , PAR = 2'd2
`endif
  } state_t;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_RECV  = 2'b01;
  localparam logic [1:0] M_CLEAR = 2'b10;
  localparam logic [1:0] M_ABORT = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] mode;
  logic [6:0] sr;
  logic [2:0] cnt;
  logic [6:0] shifted;
  logic       last_bit;

  assign mode     = {ch1, ch0};
  assign shifted  = {sr[5:0], d};
  assign last_bit = (cnt == 3'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (mode)
      M_CLEAR, M_ABORT: state_nxt = IDLE;
      M_RECV: begin
        case (state)
          IDLE: state_nxt = RECV;
`ifdef RECEPTOR_PARIDADE_EN
          RECV: state_nxt = last_bit ? PAR : RECV;
          PAR:  state_nxt = IDLE;
`else
          RECV: state_nxt = last_bit ? IDLE : RECV;
`endif
          default: state_nxt = IDLE;
        endcase
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    ocupado = (state != IDLE);
  end

`ifdef RECEPTOR_PARIDADE_EN
  logic [6:0] word_q;
  logic       erro_q;
  assign erro_paridade = erro_q;
`else
  assign erro_paridade = 1'b0;
`endif

  // valido defaults low every edge so it is a single-cycle pulse even across holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr              <= '0;
      cnt             <= '0;
      saidas_receptor <= '0;
      valido          <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
      word_q          <= '0;
      erro_q          <= 1'b0;
`endif
    end else begin
      valido <= 1'b0;
      case (mode)
        M_RECV: begin
          case (state)
            IDLE: begin
              sr  <= shifted;
              cnt <= 3'd1;
            end
            RECV: begin
              sr <= shifted;
              if (last_bit) begin
                cnt <= '0;
`ifdef RECEPTOR_PARIDADE_EN
                word_q <= shifted;
`else
                saidas_receptor <= shifted;
                valido          <= 1'b1;
`endif
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
`ifdef RECEPTOR_PARIDADE_EN
            PAR: begin
              saidas_receptor <= word_q;
              erro_q          <= ^{word_q, d};
              valido          <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
        M_CLEAR: begin
          sr              <= '0;
          cnt             <= '0;
          saidas_receptor <= '0;
`ifdef RECEPTOR_PARIDADE_EN
          erro_q          <= 1'b0;
`endif
        end
        M_ABORT: begin
          sr  <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  logic unused_hold;
  assign unused_hold = (M_HOLD == 2'b00);

endmodule
